mod_addsub_pipe: RTL and testbench
==================================

Name: mod_addsub_pipe

Overview:
- Pipelined, multi-lane modular add/subtract unit for the Kyber arithmetic datapath (NTT butterflies, polynomial add/sub).
- Generalises the single combinational subtractor: per-beat add or sub mode, LANES independent coefficients per beat, parametrised modulus and width.
- Two-stage valid/ready pipeline with full backpressure; sits between the coefficient RAM readers and the NTT/accumulate write-back.

Parameters:
- DWIDTH, 12, coefficient width in bits; must satisfy Q < 2^DWIDTH.
- Q, 3329, modulus; 2 <= Q < 2^DWIDTH.
- LANES, 4, coefficients processed in parallel per beat.
- TAG_W, 8, width of the sideband tag carried alongside each beat.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous flush: drops all in-flight beats.
- in_valid  input  1  input beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- in_op  input  1  0 = (a+b) mod Q, 1 = (a-b) mod Q; applies to all lanes.
- in_a  input  LANES*DWIDTH  operand A, lane i at bits [i*DWIDTH +: DWIDTH].
- in_b  input  LANES*DWIDTH  operand B, same packing.
- in_tag  input  TAG_W  sideband, returned unchanged with the result.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  LANES*DWIDTH  results, each lane in [0, Q-1].
- out_tag  output  TAG_W  tag of the result beat.
- err  output  1  range-error flag (see Optional Feature; tied 0 when the feature is off).

Behaviour:
- Reset (rst_n=0, asynchronous): both stage-valid bits, out_valid, out_data, out_tag and err are cleared to 0. In-flight beats are lost; no partial beat is emitted after reset release.
- Handshake: a beat transfers on in_valid&&in_ready, or on out_valid&&out_ready.
  - out_data and out_tag are held stable while out_valid && !out_ready.
  - in_valid must not depend on in_ready.
- Stage 1 (S1): registers op and tag, plus a per-lane raw value r of DWIDTH+1 bits.
  - add: r = a + b.
  - sub: r = a - b in two's complement; the MSB set means negative.
- Stage 2 (S2/output): per-lane correction.
  - add: if r >= Q then r - Q, else r.
  - sub: if r is negative then r + Q, else r.
  - The result is truncated to DWIDTH bits.
- Latency: 2 cycles from input acceptance to out_valid with no stall. Throughput is 1 beat/cycle.
- Advance rules:
  - S2 loads when S2 is empty or out_ready=1.
  - S1 loads when S1 is empty or S1 moves into S2.
  - in_ready = !s1_valid || s2_can_load. This is combinational from out_ready; there is no combinational in_valid->in_ready path.
- Full pipeline with out_ready=0: in_ready=0. Exactly 2 beats are buffered; none is dropped or duplicated; order is preserved.
- Simultaneous input accept and output drain in one cycle is allowed; the beats shift through.
- clr=1: S1 and S2 valid bits clear on the next edge, and an input presented in that cycle is discarded. clr has priority over all loads. err is not cleared by clr.
- Operands are expected in [0, Q-1]. Out-of-range operands produce an unspecified (but deterministic) out_data; no hang occurs.

Optional Feature:
- Macro: MOD_ADDSUB_RANGE_CHECK_EN.
- Defined:
  - On each accepted beat, any lane with a >= Q or b >= Q sets err to 1.
  - err is sticky until rst_n is asserted.
  - The offending beat still flows through normally.
- Not defined: err is a constant 0 and no comparators are built.

Test Plan:
- Add wrap, single lane: op=0, a=3000, b=500 -> out_data=171 two cycles later, tag preserved.
- Sub borrow: op=1, a=5, b=10 -> 3324; op=1, a=0, b=0 -> 0; op=0, a=3328, b=3328 -> 3327; op=0, a=3328, b=0 -> 3328.
- Multi-lane mixed: LANES=4, op=1, a={100,0,3328,7}, b={50,1,3328,3328} -> {50,3328,0,8}.
- Backpressure: out_ready=0 while 3 beats are offered back-to-back -> 2 accepted, in_ready=0 on the 3rd. Raise out_ready -> tags emerge in order, one per cycle, with no loss.
- Flush and reset: clr pulsed with 2 beats in flight -> out_valid=0 the next cycle and those beats are never emitted. Repeat with rst_n asserted mid-stream -> all outputs 0 immediately (asynchronously).
- With MOD_ADDSUB_RANGE_CHECK_EN: a=3329 on lane 2 -> err=1 and stays 1 after further valid beats and after clr; without the macro, err stays 0.

Source files
------------

// File: rtl/mod_addsub_pipe.sv
// mod_addsub_pipe - two-stage pipelined, multi-lane modular add/subtract unit
// for the Kyber arithmetic datapath (NTT butterflies, polynomial add/sub).
//
// Stage 1 registers the raw per-lane sum or difference (DWIDTH+1 bits, two's
// complement for subtract). Stage 2 applies a single conditional +/-Q
// correction and presents the result. Both stages use valid/ready handshakes
// with full backpressure.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous flush of all in-flight beats (err is kept)
//   in_valid   input beat valid
//   in_ready   unit can accept a beat this cycle
//   in_op      0 = (a+b) mod Q, 1 = (a-b) mod Q, shared by all lanes
//   in_a/in_b  operands, lane i at [i*DWIDTH +: DWIDTH]
//   in_tag     sideband returned unchanged with the result
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   out_data   results, each lane in [0, Q-1]
//   out_tag    tag of the result beat
//   err        sticky operand range error
//
// Optional feature macro: MOD_ADDSUB_RANGE_CHECK_EN
//   defined     : any accepted beat with a lane operand >= Q sets err (sticky
//                 until rst_n); the beat still flows through normally.
//   not defined : err is tied to 0 and no range comparators are built.
module mod_addsub_pipe #(
  parameter int DWIDTH = 12,
  parameter int Q      = 3329,
  parameter int LANES  = 4,
  parameter int TAG_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_op,
  input  logic [LANES*DWIDTH-1:0]   in_a,
  input  logic [LANES*DWIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DWIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]          out_tag,
  output logic                      err
);

  localparam int RW = DWIDTH + 1;
  localparam logic [RW-1:0] Q_R = RW'(Q);

  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_op_q, s1_op_d;
  logic [TAG_W-1:0]        s1_tag_q, s1_tag_d;
  logic [LANES*RW-1:0]     s1_raw_q, s1_raw_d;
  logic                    s2_valid_q, s2_valid_d;
  logic [LANES*DWIDTH-1:0] out_data_q, out_data_d;
  logic [TAG_W-1:0]        out_tag_q, out_tag_d;

  logic                    s2_can_load;
  logic                    s1_can_load;
  logic                    in_fire;
  logic [LANES*RW-1:0]     raw_in;
  logic [LANES*DWIDTH-1:0] corr;

  // Raw per-lane result; the extra MSB is the carry (add) or sign (sub).
  always_comb begin
    raw_in = '0;
    for (int i = 0; i < LANES; i++) begin
      if (in_op) begin
        raw_in[i*RW +: RW] = {1'b0, in_a[i*DWIDTH +: DWIDTH]} - {1'b0, in_b[i*DWIDTH +: DWIDTH]};
      end else begin
        raw_in[i*RW +: RW] = {1'b0, in_a[i*DWIDTH +: DWIDTH]} + {1'b0, in_b[i*DWIDTH +: DWIDTH]};
      end
    end
  end

  // One conditional correction per lane. The fix-up arithmetic is done in
  // DWIDTH bits: for in-range operands the true result fits, so wrapping
  // modulo 2^DWIDTH gives the same answer as the wider computation.
  always_comb begin
    corr = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s1_op_q) begin
        if (s1_raw_q[i*RW + DWIDTH]) begin
          corr[i*DWIDTH +: DWIDTH] = s1_raw_q[i*RW +: DWIDTH] + Q_R[DWIDTH-1:0];
        end else begin
          corr[i*DWIDTH +: DWIDTH] = s1_raw_q[i*RW +: DWIDTH];
        end
      end else begin
        if (s1_raw_q[i*RW +: RW] >= Q_R) begin
          corr[i*DWIDTH +: DWIDTH] = s1_raw_q[i*RW +: DWIDTH] - Q_R[DWIDTH-1:0];
        end else begin
          corr[i*DWIDTH +: DWIDTH] = s1_raw_q[i*RW +: DWIDTH];
        end
      end
    end
  end

  always_comb begin
    s2_can_load = !s2_valid_q || out_ready;
    s1_can_load = !s1_valid_q || s2_can_load;
    in_fire     = in_valid && s1_can_load;

    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_tag_d    = s1_tag_q;
    s1_raw_d    = s1_raw_q;
    s2_valid_d  = s2_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;

    if (s2_can_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = corr;
        out_tag_d  = s1_tag_q;
      end
    end

    if (s1_can_load) begin
      s1_valid_d = in_valid;
      if (in_fire) begin
        s1_op_d  = in_op;
        s1_tag_d = in_tag;
        s1_raw_d = raw_in;
      end
    end

    // Flush wins over every load; payload registers may still update but
    // are never presented without a valid bit.
    if (clr) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= 1'b0;
      s1_tag_q   <= '0;
      s1_raw_q   <= '0;
      s2_valid_q <= 1'b0;
      out_data_q <= '0;
      out_tag_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_tag_q   <= s1_tag_d;
      s1_raw_q   <= s1_raw_d;
      s2_valid_q <= s2_valid_d;
      out_data_q <= out_data_d;
      out_tag_q  <= out_tag_d;
    end
  end

  assign in_ready  = s1_can_load;
  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
  logic err_q, err_d;
  logic range_bad;

  always_comb begin
    range_bad = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (({1'b0, in_a[i*DWIDTH +: DWIDTH]} >= Q_R) || ({1'b0, in_b[i*DWIDTH +: DWIDTH]} >= Q_R)) begin
        range_bad = 1'b1;
      end
    end
    err_d = err_q || (in_fire && range_bad);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mod_addsub_pipe.sv
module tb_mod_addsub_pipe;
  localparam int DW = 12;
  localparam int Q  = 3329;
  localparam int L  = 4;
  localparam int TW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clr = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_op = 1'b0;
  logic            out_ready = 1'b0;
  logic [L*DW-1:0] in_a = '0;
  logic [L*DW-1:0] in_b = '0;
  logic [TW-1:0]   in_tag = '0;
  wire             in_ready;
  wire             out_valid;
  wire             err;
  wire [L*DW-1:0]  out_data;
  wire [TW-1:0]    out_tag;

  mod_addsub_pipe #(.DWIDTH(DW), .Q(Q), .LANES(L), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [L*DW-1:0] data;
    logic [TW-1:0]   tag;
    bit              chk_data;
  } exp_t;

  exp_t sb[$];
  exp_t cur_exp;
  int   n_assert = 0;
  int   n_fail = 0;
  logic exp_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [L*DW-1:0] model(input logic op, input logic [L*DW-1:0] a,
                                            input logic [L*DW-1:0] b);
    logic [L*DW-1:0] res;
    int x, y, r;
    res = '0;
    for (int i = 0; i < L; i++) begin
      x = int'(a[i*DW +: DW]);
      y = int'(b[i*DW +: DW]);
      r = op ? x - y : x + y;
      if (r < 0) r = r + Q;
      else if (r >= Q) r = r - Q;
      res[i*DW +: DW] = r[DW-1:0];
    end
    return res;
  endfunction

  // One clock: score any handshake due this cycle, then advance.
  task automatic cycle();
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", {63'd0, out_valid}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("out_tag", out_tag, e.tag);
        if (e.chk_data) chk("out_data", out_data, e.data);
      end
    end
    if (in_valid && in_ready && !clr) sb.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic op, input logic [L*DW-1:0] a, input logic [L*DW-1:0] b,
                          input logic [TW-1:0] tag, input logic [L*DW-1:0] exp, input bit chkd);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    cur_exp  = '{data: exp, tag: tag, chk_data: chkd};
  endtask

  task automatic send(input logic op, input logic [L*DW-1:0] a, input logic [L*DW-1:0] b,
                      input logic [TW-1:0] tag, input logic [L*DW-1:0] exp);
    set_beat(op, a, b, tag, exp, 1'b1);
    cycle();
  endtask

  task automatic drain(input int budget);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < budget && sb.size() > 0; i++) cycle();
    chk("drain_left", sb.size(), 0);
  endtask

  initial begin
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Add wrap with latency check
    out_ready = 1'b1;
    send(1'b0, {4{12'd3000}}, {4{12'd500}}, 8'hA5, {4{12'd171}});
    in_valid = 1'b0;
    chk("lat_cycle1_valid", out_valid, 0);
    cycle();
    chk("lat_cycle2_valid", out_valid, 1);
    chk("lat_add_wrap", out_data, {4{12'd171}});
    chk("lat_tag", out_tag, 8'hA5);
    drain(5);

    // Back-to-back directed corner beats
    send(1'b1, {4{12'd5}},    {4{12'd10}},   8'h01, {4{12'd3324}});
    send(1'b1, {4{12'd0}},    {4{12'd0}},    8'h02, {4{12'd0}});
    send(1'b0, {4{12'd3328}}, {4{12'd3328}}, 8'h03, {4{12'd3327}});
    send(1'b0, {4{12'd3328}}, {4{12'd0}},    8'h04, {4{12'd3328}});
    send(1'b1, {12'd100, 12'd0, 12'd3328, 12'd7}, {12'd50, 12'd1, 12'd3328, 12'd3328},
         8'h05, {12'd50, 12'd3328, 12'd0, 12'd8});
    drain(10);

    // Backpressure: third beat must be refused, order preserved on release
    out_ready = 1'b0;
    send(1'b0, {4{12'd1}}, {4{12'd2}}, 8'h10, {4{12'd3}});
    send(1'b1, {4{12'd1}}, {4{12'd2}}, 8'h11, {4{12'd3328}});
    set_beat(1'b0, {4{12'd3328}}, {4{12'd1}}, 8'h12, {4{12'd0}}, 1'b1);
    #1;
    chk("bp_in_ready_full", in_ready, 0);
    repeat (3) cycle();
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_tag", out_tag, 8'h10);
    chk("bp_hold_data", out_data, {4{12'd3}});
    chk("bp_in_ready_hold", in_ready, 0);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", in_ready, 1);
    cycle();
    drain(10);

    // Flush with two beats in flight
    out_ready = 1'b0;
    send(1'b0, {4{12'd7}}, {4{12'd8}}, 8'h20, {4{12'd15}});
    send(1'b0, {4{12'd9}}, {4{12'd8}}, 8'h21, {4{12'd17}});
    set_beat(1'b0, {4{12'd1}}, {4{12'd1}}, 8'h22, {4{12'd2}}, 1'b1);
    clr = 1'b1;
    cycle();
    chk("clr_out_valid", out_valid, 0);
    sb.delete();
    set_beat(1'b0, {4{12'd1}}, {4{12'd1}}, 8'h23, {4{12'd2}}, 1'b1);
    #1;
    chk("clr_in_ready", in_ready, 1);
    cycle();
    clr = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("clr_no_emit", out_valid, 0);
      cycle();
    end

    // Asynchronous reset mid-stream
    send(1'b0, {4{12'd10}}, {4{12'd20}}, 8'h30, {4{12'd30}});
    send(1'b0, {4{12'd11}}, {4{12'd20}}, 8'h31, {4{12'd31}});
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_tag", out_tag, 0);
    chk("arst_err", err, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("arst_no_emit", out_valid, 0);
    end

    // Range error: lane 2 operand out of range
    set_beat(1'b0, {12'd0, 12'd3329, 12'd0, 12'd0}, {4{12'd0}}, 8'h40, '0, 1'b0);
    cycle();
    in_valid = 1'b0;
    chk("err_set", err, exp_err);
    send(1'b0, {4{12'd1}}, {4{12'd1}}, 8'h41, {4{12'd2}});
    drain(10);
    chk("err_sticky_beats", err, exp_err);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    chk("err_sticky_clr", err, exp_err);

    // Random stream with random backpressure, model-checked
    for (int i = 0; i < 200; i++) begin
      logic [L*DW-1:0] a, b;
      logic            op;
      for (int j = 0; j < L; j++) begin
        a[j*DW +: DW] = 12'($urandom_range(0, Q-1));
        b[j*DW +: DW] = 12'($urandom_range(0, Q-1));
      end
      op = 1'($urandom_range(0, 1));
      set_beat(op, a, b, 8'(i), model(op, a, b), 1'b1);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0);
      cycle();
    end
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
